// File: rtl/async_fifo_ctrl_if.sv
// Handshake and memory-control bundle for async_fifo_ctrl.
//   master : producer/consumer side; drives push, pop and flush, observes everything else.
//   slave  : the controller; consumes push/pop/flush, drives addresses, enables, flags, levels.
// Signals:
//   push, pop, flush          requests (push in wclk, pop in rclk, flush quasi-static)
//   write_addr, write_enable  memory write port control (wclk)
//   read_addr, read_enable    memory read port control (rclk)
//   full, wr_level, overflow  write-domain status
//   empty, rd_level, underflow read-domain status
interface async_fifo_ctrl_if #(
    parameter int unsigned depth = 7
);
    logic             push;
    logic             pop;
    logic             flush;
    logic [depth-1:0] write_addr;
    logic             write_enable;
    logic [depth-1:0] read_addr;
    logic             read_enable;
    logic             full;
    logic             empty;
    logic [depth:0]   wr_level;
    logic [depth:0]   rd_level;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, flush,
        input  write_addr, write_enable, read_addr, read_enable,
        input  full, empty, wr_level, rd_level, overflow, underflow
    );

    modport slave (
        input  push, pop, flush,
        output write_addr, write_enable, read_addr, read_enable,
        output full, empty, wr_level, rd_level, overflow, underflow
    );
endinterface

// File: rtl/async_fifo_ctrl.sv
// Pointer and flag controller for a 2^depth-entry dual-clock FIFO memory.
// The write pointer lives in the wclk domain, the read pointer in the rclk domain; each is
// passed to the other side as a Gray code through a two-flop synchronizer, so cross-domain
// flags and levels are always pessimistic.
// Ports:
//   wclk   write-domain clock
//   rclk   read-domain clock
//   reset  synchronous active-low reset, sampled separately in each domain
//   bus    async_fifo_ctrl_if slave modport (requests, memory control, flags, levels)
module async_fifo_ctrl #(
    parameter int unsigned depth     = 7,
    parameter int unsigned mem_depth = 128
) (
    input  logic                 wclk,
    input  logic                 rclk,
    input  logic                 reset,
    async_fifo_ctrl_if.slave     bus
);

    if (mem_depth != (2 ** depth)) begin : g_bad_depth
        $error("async_fifo_ctrl: mem_depth must equal 2**depth");
    end

    function automatic logic [depth:0] gray2bin(input logic [depth:0] g);
        logic [depth:0] b;
        b[depth] = g[depth];
        for (int i = int'(depth) - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Write domain
    logic [depth:0] wbin;
    logic [depth:0] wgray;
    logic [depth:0] wbin_next;
    logic [depth:0] rq1;
    logic [depth:0] rq2;
    logic           wf1;
    logic           wf2;
    logic           wflush;
    logic           full;
    logic           write_enable;
    logic           ovf;

    // Read domain
    logic [depth:0] rbin;
    logic [depth:0] rgray;
    logic [depth:0] rbin_next;
    logic [depth:0] wq1;
    logic [depth:0] wq2;
    logic           rf1;
    logic           rf2;
    logic           rflush;
    logic           empty;
    logic           read_enable;
    logic           unf;

    assign wflush    = wf2;
    assign wbin_next = wbin + (depth+1)'(1);

    // Full when the write pointer is exactly one lap ahead: in Gray code that is the
    // synced read pointer with its two top bits inverted.
    assign full         = (wgray == {~rq2[depth:depth-1], rq2[depth-2:0]});
    assign write_enable = bus.push & ~full & ~wflush;

    always_ff @(posedge wclk) begin
        if (!reset) begin
            wbin  <= '0;
            wgray <= '0;
            rq1   <= '0;
            rq2   <= '0;
            wf1   <= 1'b0;
            wf2   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            wf1 <= bus.flush;
            wf2 <= wf1;
            if (wflush) begin
                wbin  <= '0;
                wgray <= '0;
                rq1   <= '0;
                rq2   <= '0;
                ovf   <= 1'b0;
            end else begin
                rq1 <= rgray;
                rq2 <= rq1;
                if (write_enable) begin
                    wbin  <= wbin_next;
                    wgray <= wbin_next ^ (wbin_next >> 1);
                end
                if (bus.push && full) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign rflush    = rf2;
    assign rbin_next = rbin + (depth+1)'(1);

    assign empty       = (rgray == wq2);
    assign read_enable = bus.pop & ~empty & ~rflush;

    always_ff @(posedge rclk) begin
        if (!reset) begin
            rbin  <= '0;
            rgray <= '0;
            wq1   <= '0;
            wq2   <= '0;
            rf1   <= 1'b0;
            rf2   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            rf1 <= bus.flush;
            rf2 <= rf1;
            if (rflush) begin
                rbin  <= '0;
                rgray <= '0;
                wq1   <= '0;
                wq2   <= '0;
                unf   <= 1'b0;
            end else begin
                wq1 <= wgray;
                wq2 <= wq1;
                if (read_enable) begin
                    rbin  <= rbin_next;
                    rgray <= rbin_next ^ (rbin_next >> 1);
                end
                if (bus.pop && empty) begin
                    unf <= 1'b1;
                end
            end
        end
    end

    assign bus.write_addr   = wbin[depth-1:0];
    assign bus.write_enable = write_enable;
    assign bus.full         = full;
    // Modular subtraction keeps the level correct across pointer wrap; equals 2^depth when full.
    assign bus.wr_level     = wbin - gray2bin(rq2);
    assign bus.overflow     = ovf;

    assign bus.read_addr    = rbin[depth-1:0];
    assign bus.read_enable  = read_enable;
    assign bus.empty        = empty;
    assign bus.rd_level     = gray2bin(wq2) - rbin;
    assign bus.underflow    = unf;

endmodule
